// File: rtl/rng_request_arbiter.sv
// Round-robin sequencer sharing one 4-bit LFSR bit source among NUM_REQ requesters.
// Each grant collects WORD_W successive LFSR bits (first bit ends up as MSB) and pulses valid.
module rng_request_arbiter #(
  parameter int         NUM_REQ  = 2,
  parameter int         WORD_W   = 4,
  parameter logic [3:0] SEED     = 4'b1010,
  parameter int         FREE_RUN = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               reseed_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [NUM_REQ-1:0] valid_o,
  output logic [WORD_W-1:0]  rnd_word_o,
  output logic               lfsr_load_o,
  output logic [3:0]         lfsr_seed_o,
  output logic               lfsr_step_o,
  input  logic               lfsr_bit_i
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic FREE_RUN_B = (FREE_RUN != 0) ? 1'b1 : 1'b0;
  localparam logic [NUM_REQ-1:0] ONE_HOT = NUM_REQ'(1'b1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  if (SEED == 4'b0000) begin : g_bad_seed
    $error("rng_request_arbiter: SEED of zero locks up the LFSR");
  end
  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
    $error("rng_request_arbiter: NUM_REQ must be 2..4");
  end
  if (WORD_W < 1 || WORD_W > 8) begin : g_bad_word_w
    $error("rng_request_arbiter: WORD_W must be 1..8");
  end

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] valid_q;
  logic [WORD_W-1:0]  word_q;
  logic [WORD_W-1:0]  word_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   win_q;
  logic               pend_q;
  logic               load_q;
  logic               step_q;

  logic               win_found_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic [IDX_W-1:0]   cand_s;

  // Rotating-priority search starting one past the last served requester.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found_s && req_i[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  if (WORD_W == 1) begin : g_w1
    assign word_d = lfsr_bit_i;
  end else begin : g_wn
    logic [WORD_W-2:0] shift_q;
    assign word_d = {shift_q, lfsr_bit_i};

    // Holds the bits collected so far; the word is this plus the current LFSR bit.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        shift_q <= '0;
      end else if (state_q == S_SHIFT) begin
        shift_q <= word_d[WORD_W-2:0];
      end else begin
        shift_q <= shift_q;
      end
    end
  end

  // Sequencer FSM with registered grant, valid, word and LFSR controls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_INIT;
      gnt_q   <= '0;
      valid_q <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      win_q   <= '0;
      pend_q  <= 1'b0;
      load_q  <= 1'b1;
      step_q  <= 1'b0;
    end else begin
      valid_q <= '0;
      case (state_q)
        S_INIT: begin
          state_q <= S_IDLE;
          pend_q  <= reseed_i;
          load_q  <= 1'b0;
          step_q  <= FREE_RUN_B;
        end
        S_IDLE: begin
          // A pending or live reseed wins over any request.
          if (reseed_i || pend_q) begin
            state_q <= S_INIT;
            pend_q  <= 1'b0;
            load_q  <= 1'b1;
            step_q  <= 1'b0;
          end else if (win_found_s) begin
            state_q <= S_SHIFT;
            gnt_q   <= ONE_HOT << win_idx_s;
            win_q   <= win_idx_s;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            step_q  <= 1'b1;
          end else begin
            load_q  <= 1'b0;
            step_q  <= FREE_RUN_B;
          end
        end
        S_SHIFT: begin
          pend_q <= pend_q | reseed_i;
          cnt_q  <= cnt_q + CNT_W'(1'b1);
          if (cnt_q == CNT_LAST) begin
            state_q <= S_DONE;
            word_q  <= word_d;
            valid_q <= gnt_q;
            step_q  <= FREE_RUN_B;
          end else begin
            step_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          ptr_q   <= win_q;
          pend_q  <= pend_q | reseed_i;
          step_q  <= FREE_RUN_B;
        end
        default: begin
          state_q <= S_INIT;
          gnt_q   <= '0;
          load_q  <= 1'b1;
          step_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign valid_o     = valid_q;
  assign rnd_word_o  = word_q;
  assign lfsr_load_o = load_q;
  assign lfsr_step_o = step_q;
  assign lfsr_seed_o = SEED;

endmodule

// File: tb/tb_rng_request_arbiter.sv
// Directed bench: two arbiters (FREE_RUN=0 and FREE_RUN=1), each driving its own 4-bit LFSR model.
module tb_rng_request_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic       reseed = 1'b0;

  logic [1:0] gnt0, valid0, gnt1, valid1;
  logic [3:0] word0, word1, seed0, seed1, q0, q1;
  logic       load0, step0, load1, step1, bit0, bit1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  rng_request_arbiter #(.NUM_REQ(2), .WORD_W(4), .SEED(4'b1010), .FREE_RUN(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .reseed_i(reseed),
    .gnt_o(gnt0), .valid_o(valid0), .rnd_word_o(word0),
    .lfsr_load_o(load0), .lfsr_seed_o(seed0), .lfsr_step_o(step0), .lfsr_bit_i(bit0)
  );

  rng_request_arbiter #(.NUM_REQ(2), .WORD_W(4), .SEED(4'b1010), .FREE_RUN(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .reseed_i(reseed),
    .gnt_o(gnt1), .valid_o(valid1), .rnd_word_o(word1),
    .lfsr_load_o(load1), .lfsr_seed_o(seed1), .lfsr_step_o(step1), .lfsr_bit_i(bit1)
  );

  // LFSR cores: load seed, or shift left taking feedback q[3]^q[2].
  always @(posedge clk) begin
    if (load0) q0 <= seed0;
    else if (step0) q0 <= {q0[2:0], q0[3] ^ q0[2]};
    if (load1) q1 <= seed1;
    else if (step1) q1 <= {q1[2:0], q1[3] ^ q1[2]};
  end
  assign bit0 = q0[3] ^ q0[2];
  assign bit1 = q1[3] ^ q1[2];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Leaves the bench in cycle 0 (INIT) with rst low.
  task automatic do_reset();
    rst    = 1'b1;
    req    = 2'b00;
    reseed = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    // Scenario 1/2: single requester, both FREE_RUN settings
    do_reset();
    chk("rst_gnt", 8'(gnt0), 8'h00);
    chk("rst_valid", 8'(valid0), 8'h00);
    chk("rst_word", 8'(word0), 8'h00);
    chk("rst_step0", 8'(step0), 8'h00);
    chk("rst_step1", 8'(step1), 8'h00);
    chk("c0_load", 8'(load0), 8'h01);
    tick();
    chk("c1_load", 8'(load0), 8'h00);
    chk("c1_step0", 8'(step0), 8'h00);
    chk("c1_step1", 8'(step1), 8'h01);
    req = 2'b01;
    for (int c = 2; c <= 6; c++) begin
      tick();
      chk("s1_gnt", 8'(gnt0), 8'h01);
      chk("s1_load", 8'(load0), 8'h00);
      chk("s1_step0", 8'(step0), (c <= 5) ? 8'h01 : 8'h00);
      chk("s1_step1", 8'(step1), 8'h01);
      chk("s1_valid", 8'(valid0), (c == 6) ? 8'h01 : 8'h00);
    end
    chk("s1_word_fr0", 8'(word0), 8'h0F);
    chk("s1_word_fr1", 8'(word1), 8'h0E);
    chk("s1_valid_fr1", 8'(valid1), 8'h01);
    req = 2'b00;
    tick();
    chk("s1_c7_gnt", 8'(gnt0), 8'h00);
    chk("s1_c7_valid", 8'(valid0), 8'h00);
    chk("s1_c7_word_held", 8'(word0), 8'h0F);

    // Scenario 3: both requesters held, round-robin alternation
    do_reset();
    tick();
    req = 2'b11;
    for (int c = 2; c <= 18; c++) begin
      tick();
      chk("s3_gnt", 8'(gnt0), (c <= 6) ? 8'h01 : (c == 7) ? 8'h00 :
                              (c <= 12) ? 8'h02 : (c == 13) ? 8'h00 : 8'h01);
      chk("s3_valid", 8'(valid0), (c == 6) ? 8'h01 : (c == 12) ? 8'h02 :
                                  (c == 18) ? 8'h01 : 8'h00);
      if (c == 6) chk("s3_word_a", 8'(word0), 8'h0F);
      else if (c == 12) chk("s3_word_b", 8'(word0), 8'h01);
      else if (c == 18) chk("s3_word_c", 8'(word0), 8'h03);
    end

    // Scenario 4: reseed pulsed during the second request's SHIFT
    do_reset();
    tick();
    req = 2'b11;
    for (int c = 2; c <= 20; c++) begin
      tick();
      reseed = (c == 9);
      chk("s4_load", 8'(load0), (c == 14) ? 8'h01 : 8'h00);
      chk("s4_valid", 8'(valid0), (c == 6) ? 8'h01 : (c == 12) ? 8'h02 :
                                  (c == 20) ? 8'h01 : 8'h00);
      chk("s4_gnt", 8'(gnt0), (c <= 6) ? 8'h01 : (c == 7) ? 8'h00 :
                              (c <= 12) ? 8'h02 : (c <= 15) ? 8'h00 : 8'h01);
      if (c == 12) chk("s4_word_b", 8'(word0), 8'h01);
      else if (c == 14) chk("s4_init_step", 8'(step0), 8'h00);
      else if (c == 20) chk("s4_word_reseeded", 8'(word0), 8'h0F);
    end

    // Scenario 5: rst mid-SHIFT abandons the service
    do_reset();
    tick();
    req = 2'b01;
    tick();
    tick();
    chk("s5_c3_gnt", 8'(gnt0), 8'h01);
    rst = 1'b1;
    tick();
    chk("s5_abort_gnt", 8'(gnt0), 8'h00);
    chk("s5_abort_valid", 8'(valid0), 8'h00);
    chk("s5_abort_word", 8'(word0), 8'h00);
    chk("s5_abort_load", 8'(load0), 8'h01);
    rst = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("s5_valid", 8'(valid0), (c == 6) ? 8'h01 : 8'h00);
    end
    chk("s5_word", 8'(word0), 8'h0F);

    // Scenario 6: req dropped mid-service still gets its word
    do_reset();
    tick();
    req = 2'b01;
    tick();
    tick();
    req = 2'b00;
    for (int c = 4; c <= 9; c++) begin
      tick();
      chk("s6_gnt", 8'(gnt0), (c <= 6) ? 8'h01 : 8'h00);
      chk("s6_valid", 8'(valid0), (c == 6) ? 8'h01 : 8'h00);
      if (c == 6) chk("s6_word", 8'(word0), 8'h0F);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
